// File: rtl/mci_arbiter_2to1.sv
// Round-robin arbiter between the instruction cache (port 0) and the data cache (port 1)
// in front of one memory controller; one outstanding transaction, response routed to the owner.
module mci_arbiter_2to1 #(
    parameter int ADDR_LENGTH     = 32,
    parameter int MCI_DATA_LENGTH = 128
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      req_valid_i,
    input  logic [1:0]                      req_rw_i,
    input  logic [1:0][ADDR_LENGTH-1:0]     req_addr_i,
    input  logic [1:0][MCI_DATA_LENGTH-1:0] req_data_i,
    output logic [1:0]                      rsp_ready_o,
    output logic [MCI_DATA_LENGTH-1:0]      rsp_data_o,
    output logic                            mem_req_valid_o,
    output logic                            mem_req_rw_o,
    output logic [ADDR_LENGTH-1:0]          mem_req_addr_o,
    output logic [MCI_DATA_LENGTH-1:0]      mem_req_data_o,
    input  logic                            mem_res_ready_i,
    input  logic [MCI_DATA_LENGTH-1:0]      mem_res_data_i,
    output logic                            proto_err_o
);

    typedef enum logic {IDLE, WAIT} state_e;

    state_e                            state_q, state_d;
    logic                              grant_q, grant_d;
    logic                              last_grant_q, last_grant_d;
    logic                              mem_req_valid_q, mem_req_valid_d;
    logic                              proto_err_q, proto_err_d;
    logic [1:0]                        pend_q, pend_d;
    logic [1:0]                        rw_q, rw_d;
    logic [1:0][ADDR_LENGTH-1:0]       addr_q, addr_d;
    logic [1:0][MCI_DATA_LENGTH-1:0]   data_q, data_d;

    logic       done;
    logic [1:0] completing;
    logic [1:0] capture;

    assign done = (state_q == WAIT) && mem_res_ready_i;

    // A port may re-request in its own completion cycle; that refills the slot instead of erroring.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        completing = 2'b00;
        if (done) completing[grant_q] = 1'b1;

        capture = req_valid_i & (~pend_q | completing);
        pend_d  = (pend_q & ~completing) | capture;
        proto_err_d = proto_err_q | (|(req_valid_i & pend_q & ~completing));

        rw_d   = rw_q;
        addr_d = addr_q;
        data_d = data_q;
        for (int i = 0; i < 2; i++) begin
            if (capture[i]) begin
                rw_d[i]   = req_rw_i[i];
                addr_d[i] = req_addr_i[i];
                data_d[i] = req_data_i[i];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_grant_d    = last_grant_q;
        mem_req_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    // Tie goes to the port not served last; otherwise the lone pending port.
                    grant_d         = (&pend_q) ? ~last_grant_q : pend_q[1];
                    state_d         = WAIT;
                    mem_req_valid_d = 1'b1;
                end
            end
            WAIT: begin
                if (mem_res_ready_i) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
        endcase
    end

    always_comb begin
        rsp_ready_o    = completing;
        rsp_data_o     = done ? mem_res_data_i : '0;
        mem_req_rw_o   = 1'b0;
        mem_req_addr_o = '0;
        mem_req_data_o = '0;
        if (state_q == WAIT) begin
            mem_req_rw_o   = rw_q[grant_q];
            mem_req_addr_o = addr_q[grant_q];
            mem_req_data_o = data_q[grant_q];
        end
    end

    assign mem_req_valid_o = mem_req_valid_q;
    assign proto_err_o     = proto_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            grant_q         <= 1'b0;
            last_grant_q    <= 1'b1;
            mem_req_valid_q <= 1'b0;
            proto_err_q     <= 1'b0;
            pend_q          <= 2'b00;
            rw_q            <= 2'b00;
            addr_q          <= '0;
            data_q          <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q         <= state_d;
            grant_q         <= grant_d;
            last_grant_q    <= last_grant_d;
            mem_req_valid_q <= mem_req_valid_d;
            proto_err_q     <= proto_err_d;
            pend_q          <= pend_d;
            rw_q            <= rw_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
        end
    end

endmodule
